// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state encoding,
// counter sizing and the per-state output decode.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_sup_state_e;

  typedef struct packed {
    logic pll_rst;
    logic rst_n;
    logic ready;
    logic fail;
  } pll_sup_out_t;

  // Width of a counter that must hold 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Output levels that belong to each state; registered by the caller.
  function automatic pll_sup_out_t state_outputs(input pll_sup_state_e st);
    pll_sup_out_t o;
    o = '{pll_rst: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
    case (st)
      ST_PLL_RST:   o = '{pll_rst: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
      ST_WAIT_LOCK: o = '{pll_rst: 1'b0, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
      ST_STABLE:    o = '{pll_rst: 1'b0, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
      ST_RUN:       o = '{pll_rst: 1'b0, rst_n: 1'b1, ready: 1'b1, fail: 1'b0};
      ST_FAIL:      o = '{pll_rst: 1'b0, rst_n: 1'b0, ready: 1'b0, fail: 1'b1};
      default:      o = '{pll_rst: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag into clk_i.
module pll_sup_sync #(
  parameter int STAGES = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the flop chain; cleared to 0 on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, releases
// the downstream reset, re-arms on lock loss and gives up after a bounded
// number of retries until software forces a new attempt.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES           = 3,
  parameter int RST_PULSE_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES    = 1024,
  parameter int RELOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES           = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       locked_i,
  input  logic       force_rst_i,
  output logic       pll_rst_o,
  output logic       rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int RstW   = cnt_width(RST_PULSE_CYCLES);
  localparam int StW    = cnt_width(LOCK_STABLE_CYCLES);
  localparam int ToW    = cnt_width(RELOCK_TIMEOUT_CYCLES);
  localparam int RetryW = 4;

  localparam logic [RstW-1:0]   RstLast   = RstW'(RST_PULSE_CYCLES - 1);
  localparam logic [StW-1:0]    StLast    = StW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [ToW-1:0]    ToLast    = ToW'(RELOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MAX_RETRIES);

  logic locked_s;

  pll_sup_state_e    state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [StW-1:0]    st_cnt_q, st_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        loss_q, loss_d;
  pll_sup_out_t      out_d;

  pll_sup_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (locked_i),
    .q_o     (locked_s)
  );

  // Next-state and counter update; a software request overrides everything.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    st_cnt_d  = st_cnt_q;
    to_cnt_d  = to_cnt_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    if (force_rst_i) begin
      state_d   = ST_PLL_RST;
      rst_cnt_d = '0;
      st_cnt_d  = '0;
      to_cnt_d  = '0;
      retry_d   = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (rst_cnt_q == RstLast) begin
            state_d   = ST_WAIT_LOCK;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RstW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d  = ST_STABLE;
            st_cnt_d = '0;
            to_cnt_d = '0;
          end else if (to_cnt_q == ToLast) begin
            to_cnt_d = '0;
            if (retry_q == RetryLast) begin
              state_d = ST_FAIL;
            end else begin
              state_d   = ST_PLL_RST;
              rst_cnt_d = '0;
              retry_d   = retry_q + RetryW'(1);
            end
          end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            // Lock glitch: start the wait afresh, including the timeout.
            state_d  = ST_WAIT_LOCK;
            st_cnt_d = '0;
            to_cnt_d = '0;
          end else if (st_cnt_q == StLast) begin
            state_d  = ST_RUN;
            st_cnt_d = '0;
            retry_d  = '0;
          end else begin
            st_cnt_d = st_cnt_q + StW'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d   = ST_PLL_RST;
            rst_cnt_d = '0;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 8'd1;
            end else begin
              loss_d = loss_q;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d   = ST_PLL_RST;
          rst_cnt_d = '0;
          st_cnt_d  = '0;
          to_cnt_d  = '0;
        end
      endcase
    end
    out_d = state_outputs(state_d);
  end

  // State, counters and outputs register together so outputs change on entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_PLL_RST;
      rst_cnt_q       <= '0;
      st_cnt_q        <= '0;
      to_cnt_q        <= '0;
      retry_q         <= '0;
      loss_q          <= 8'd0;
      pll_rst_o       <= 1'b1;
      rst_n_o         <= 1'b0;
      ready_o         <= 1'b0;
      fail_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      st_cnt_q        <= st_cnt_d;
      to_cnt_q        <= to_cnt_d;
      retry_q         <= retry_d;
      loss_q          <= loss_d;
      pll_rst_o       <= out_d.pll_rst;
      rst_n_o         <= out_d.rst_n;
      ready_o         <= out_d.ready;
      fail_o          <= out_d.fail;
    end
  end

  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       force_rst;
  logic       pll_rst;
  logic       rst_n_out;
  logic       ready;
  logic       fail;
  logic [7:0] loss;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Observation results (k = negedge sample index from the start of observe)
  int pulse_n;
  int pulse_start [0:7];
  int pulse_len   [0:7];
  int ready_rise;
  int fail_first;
  int rstn_fall;

  pll_lock_supervisor #(
    .SYNC_STAGES           (2),
    .RST_PULSE_CYCLES      (4),
    .LOCK_STABLE_CYCLES    (8),
    .RELOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES           (2)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .locked_i        (locked),
    .force_rst_i     (force_rst),
    .pll_rst_o       (pll_rst),
    .rst_n_o         (rst_n_out),
    .ready_o         (ready),
    .fail_o          (fail),
    .lock_loss_cnt_o (loss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic lv);
    @(negedge clk);
    rst_n     = 1'b0;
    force_rst = 1'b0;
    locked    = lv;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sample n negedges, optionally dropping locked_i or raising force_rst_i.
  task automatic observe(input int n, input int drop_at, input int drop_len,
                         input int force_at, input int force_len);
    logic prev_pll;
    logic prev_ready;
    prev_pll   = 1'b0;
    prev_ready = 1'b1;
    pulse_n    = 0;
    ready_rise = -1;
    fail_first = -1;
    rstn_fall  = -1;
    for (int i = 0; i < 8; i++) begin
      pulse_start[i] = -1;
      pulse_len[i]   = 0;
    end
    for (int k = 0; k < n; k++) begin
      if (pll_rst && !prev_pll) begin
        if (pulse_n < 8) pulse_start[pulse_n] = k;
        pulse_n++;
      end
      if (pll_rst && pulse_n > 0 && pulse_n <= 8) pulse_len[pulse_n-1]++;
      if (ready && !prev_ready && ready_rise < 0) ready_rise = k;
      if (fail && fail_first < 0) fail_first = k;
      if (!rst_n_out && rstn_fall < 0) rstn_fall = k;
      prev_pll   = pll_rst;
      prev_ready = ready;
      if (drop_at >= 0 && k == drop_at) locked = 1'b0;
      if (drop_at >= 0 && k == drop_at + drop_len) locked = 1'b1;
      if (force_at >= 0 && k == force_at) force_rst = 1'b1;
      if (force_at >= 0 && k == force_at + force_len) force_rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; locked = 1'b1; force_rst = 1'b0;
    #1;
    chk_cnt++; if ({pll_rst, rst_n_out, ready, fail} !== 4'b1000) $display("FAIL reset_outs: got %b expected 1000", {pll_rst, rst_n_out, ready, fail}); else pass_cnt++;
    chk_cnt++; if (loss !== 8'd0) $display("FAIL reset_loss: got %0d expected 0", loss); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(40, -1, 0, -1, 0);
    chk_cnt++; if (pulse_n !== 1 || pulse_start[0] !== 0 || pulse_len[0] !== 4) $display("FAIL reset_pulse: got n=%0d start=%0d len=%0d expected n=1 start=0 len=4", pulse_n, pulse_start[0], pulse_len[0]); else pass_cnt++;
    chk_cnt++; if (ready_rise !== 13) $display("FAIL reset_ready_at: got %0d expected 13", ready_rise); else pass_cnt++;
    chk_cnt++; if ({rst_n_out, ready, fail, loss} !== {1'b1, 1'b1, 1'b0, 8'd0}) $display("FAIL run_outs: got rst_n=%b ready=%b fail=%b loss=%0d expected 1 1 0 0", rst_n_out, ready, fail, loss); else pass_cnt++;
    // Asynchronous reset in the middle of RUN
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({pll_rst, rst_n_out, ready, fail} !== 4'b1000) $display("FAIL midop_reset: got %b expected 1000", {pll_rst, rst_n_out, ready, fail}); else pass_cnt++;
  endtask

  task automatic test_stable_drop;
    do_reset(1'b1);
    observe(40, 8, 1, -1, 0);
    chk_cnt++; if (pulse_n !== 1 || pulse_len[0] !== 4) $display("FAIL stable_pulse: got n=%0d len=%0d expected n=1 len=4", pulse_n, pulse_len[0]); else pass_cnt++;
    chk_cnt++; if (ready_rise !== 20) $display("FAIL stable_drop_ready_at: got %0d expected 20", ready_rise); else pass_cnt++;
    chk_cnt++; if (loss !== 8'd0) $display("FAIL stable_drop_loss: got %0d expected 0", loss); else pass_cnt++;
  endtask

  task automatic test_run_loss;
    do_reset(1'b1);
    observe(20, -1, 0, -1, 0);
    chk_cnt++; if (ready !== 1'b1) $display("FAIL run_loss_pre_ready: got %b expected 1", ready); else pass_cnt++;
    observe(30, 0, 1, -1, 0);
    chk_cnt++; if (rstn_fall !== 3) $display("FAIL run_loss_rstn_fall: got %0d expected 3", rstn_fall); else pass_cnt++;
    chk_cnt++; if (pulse_n !== 1 || pulse_start[0] !== 3 || pulse_len[0] !== 4) $display("FAIL run_loss_pulse: got n=%0d start=%0d len=%0d expected n=1 start=3 len=4", pulse_n, pulse_start[0], pulse_len[0]); else pass_cnt++;
    chk_cnt++; if (ready_rise !== 16) $display("FAIL run_loss_ready_at: got %0d expected 16", ready_rise); else pass_cnt++;
    chk_cnt++; if (loss !== 8'd1) $display("FAIL run_loss_cnt: got %0d expected 1", loss); else pass_cnt++;
  endtask

  task automatic test_force_held;
    observe(30, -1, 0, 0, 6);
    chk_cnt++; if (pulse_n !== 1 || pulse_start[0] !== 1 || pulse_len[0] !== 9) $display("FAIL force_held_pulse: got n=%0d start=%0d len=%0d expected n=1 start=1 len=9", pulse_n, pulse_start[0], pulse_len[0]); else pass_cnt++;
    chk_cnt++; if (ready_rise !== 19) $display("FAIL force_held_ready_at: got %0d expected 19", ready_rise); else pass_cnt++;
    chk_cnt++; if (loss !== 8'd1) $display("FAIL force_held_loss: got %0d expected 1", loss); else pass_cnt++;
  endtask

  task automatic check_no_lock_run(input string tag);
    chk_cnt++; if (pulse_n !== 3) $display("FAIL %s_pulses: got %0d expected 3", tag, pulse_n); else pass_cnt++;
    chk_cnt++; if (pulse_start[0] !== 0 || pulse_start[1] !== 36 || pulse_start[2] !== 72) $display("FAIL %s_starts: got %0d %0d %0d expected 0 36 72", tag, pulse_start[0], pulse_start[1], pulse_start[2]); else pass_cnt++;
    chk_cnt++; if (pulse_len[0] !== 4 || pulse_len[1] !== 4 || pulse_len[2] !== 4) $display("FAIL %s_lens: got %0d %0d %0d expected 4 4 4", tag, pulse_len[0], pulse_len[1], pulse_len[2]); else pass_cnt++;
    chk_cnt++; if (fail_first !== 108) $display("FAIL %s_fail_at: got %0d expected 108", tag, fail_first); else pass_cnt++;
    chk_cnt++; if ({pll_rst, rst_n_out, ready, fail} !== 4'b0001) $display("FAIL %s_fail_outs: got %b expected 0001", tag, {pll_rst, rst_n_out, ready, fail}); else pass_cnt++;
  endtask

  task automatic test_no_lock;
    do_reset(1'b0);
    observe(120, -1, 0, -1, 0);
    check_no_lock_run("no_lock");
  endtask

  task automatic test_force_from_fail;
    force_rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (fail !== 1'b0 || pll_rst !== 1'b1) $display("FAIL force_exit_fail: got fail=%b pll_rst=%b expected 0 1", fail, pll_rst); else pass_cnt++;
    force_rst = 1'b0;
    observe(120, -1, 0, -1, 0);
    check_no_lock_run("refail");
  endtask

  task automatic test_saturation;
    do_reset(1'b1);
    observe(20, -1, 0, -1, 0);
    for (int i = 1; i <= 256; i++) begin
      observe(20, 0, 1, -1, 0);
      if (i == 254) begin
        chk_cnt++; if (loss !== 8'd254) $display("FAIL sat_254: got %0d expected 254", loss); else pass_cnt++;
      end
      if (i == 255) begin
        chk_cnt++; if (loss !== 8'd255) $display("FAIL sat_255: got %0d expected 255", loss); else pass_cnt++;
      end
    end
    chk_cnt++; if (loss !== 8'd255) $display("FAIL sat_256: got %0d expected 255", loss); else pass_cnt++;
    chk_cnt++; if (ready !== 1'b1) $display("FAIL sat_ready: got %b expected 1", ready); else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    locked    = 1'b0;
    force_rst = 1'b0;
    test_reset();
    test_stable_drop();
    test_run_loss();
    test_force_held();
    test_no_lock();
    test_force_from_fail();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
